// File: rtl/frame_loader_pkg.sv
// frame_loader_pkg: shared frame geometry, ASCII codes and byte classifiers for the frame loader.
package frame_loader_pkg;
    localparam int PX_WIDTH  = 160;
    localparam int PX_HEIGHT = 120;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_7  = 8'h37;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    function automatic logic is_pix(input logic [7:0] b);
        return (b >= CH_0) && (b <= CH_7);
    endfunction
    function automatic logic is_lf(input logic [7:0] b);
        return b == CH_LF;
    endfunction
    function automatic logic is_cr(input logic [7:0] b);
        return b == CH_CR;
    endfunction
endpackage

// File: rtl/frame_loader_if.sv
// frame_loader_if: byte stream in, framebuffer write port and frame status out.
interface frame_loader_if #(parameter int ADDR_W = 16);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              fb_busy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [2:0]        wr_data;
    logic              frame_done;
    logic              frame_ok;
    logic [15:0]       frame_cnt;
    modport master (
        output in_valid, in_data, fb_busy,
        input  in_ready, wr_en, wr_addr, wr_data, frame_done, frame_ok, frame_cnt
    );
    modport slave (
        input  in_valid, in_data, fb_busy,
        output in_ready, wr_en, wr_addr, wr_data, frame_done, frame_ok, frame_cnt
    );
endinterface

// File: rtl/frame_loader.sv
// frame_loader: decodes an ASCII pixel stream ('0'..'7' per pixel, '\n' per frame) into framebuffer writes.
module frame_loader #(
    parameter int PX_WIDTH  = frame_loader_pkg::PX_WIDTH,
    parameter int PX_HEIGHT = frame_loader_pkg::PX_HEIGHT,
    parameter int ADDR_W    = 16
) (
    input logic           clk,
    input logic           clr,
    frame_loader_if.slave bus
);
    import frame_loader_pkg::*;
    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [ADDR_W-1:0] NPIX = ADDR_W'(PX_WIDTH * PX_HEIGHT);
    logic [1:0]        state;
    logic [ADDR_W-1:0] pix_idx;
    logic              err;
    logic              acc;
    assign bus.in_ready = (state != S_DONE) & ~bus.fb_busy & ~clr;
    assign acc = bus.in_valid & bus.in_ready;
    // frame_done/frame_ok are raised on the '\n' edge so they coincide with the S_DONE cycle
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state          <= S_RUN;
            pix_idx        <= '0;
            err            <= 1'b0;
            bus.wr_en      <= 1'b0;
            bus.wr_addr    <= '0;
            bus.wr_data    <= '0;
            bus.frame_done <= 1'b0;
            bus.frame_ok   <= 1'b0;
            bus.frame_cnt  <= '0;
        end else begin
            bus.wr_en      <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.frame_ok   <= 1'b0;
            if (state == S_DONE) begin
                state   <= S_RUN;
                pix_idx <= '0;
                err     <= 1'b0;
            end else if (acc && is_lf(bus.in_data)) begin
                state          <= S_DONE;
                bus.frame_done <= 1'b1;
                bus.frame_ok   <= ~err & (pix_idx == NPIX);
                bus.frame_cnt  <= bus.frame_cnt + 16'd1;
            end else if (acc && state == S_RUN) begin
                if (is_pix(bus.in_data)) begin
                    if (pix_idx != NPIX) begin
                        bus.wr_en   <= 1'b1;
                        bus.wr_addr <= pix_idx;
                        bus.wr_data <= bus.in_data[2:0];
                        pix_idx     <= pix_idx + 1'b1;
                    end else begin
                        err   <= 1'b1;
                        state <= S_FLUSH;
                    end
                end else if (!is_cr(bus.in_data)) begin
                    err <= 1'b1;
                end
            end
        end
    end
endmodule
